// File: rtl/square_freq_timer.sv
// -----------------------------------------------------------------------------
// square_freq_timer
//
// Frequency timer and channel-1 style frequency sweep for a square-wave
// channel. Emits a one-cycle `step` pulse every (2048 - freq) * PRESCALE
// clocks, which advances the downstream duty cycler. On each qualifying
// 128 Hz `sweep_tick` the current frequency is shifted up or down, and the
// channel is disabled when the sweep would overflow 11 bits.
//
// Parameters:
//   PRESCALE      clk cycles per period-counter decrement (1..16)
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   trigger       1-cycle pulse, (re)starts the channel
//   freq_in[10:0] frequency loaded on trigger / freq_we
//   freq_we       1-cycle pulse, updates the current frequency
//   sweep_period  sweep period in sweep_tick units, 0 = sweep off
//   sweep_negate  1 = subtract, 0 = add
//   sweep_shift   right-shift amount of the sweep delta
//   sweep_tick    1-cycle 128 Hz pulse from the frame sequencer
//   step          1-cycle pulse to the duty cycler (registered)
//   freq_out      current, possibly swept, frequency (registered)
//   enabled       channel-active flag (registered)
// -----------------------------------------------------------------------------
module square_freq_timer #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        trigger,
   input  logic [10:0] freq_in,
   input  logic        freq_we,
   input  logic [2:0]  sweep_period,
   input  logic        sweep_negate,
   input  logic [2:0]  sweep_shift,
   input  logic        sweep_tick,
   output logic        step,
   output logic [10:0] freq_out,
   output logic        enabled
);

   localparam logic [3:0] PRE_MAX = 4'(PRESCALE - 1);

   // Sweep arithmetic in 12 bits so that an add overflow shows up in bit 11.
   // A subtraction can never underflow because the delta is at most freq.
   function automatic logic [11:0] sweep_calc(input logic [10:0] f,
                                              input logic        neg,
                                              input logic [2:0]  sh);
      logic [11:0] delta;
      delta = {1'b0, f} >> sh;
      if (neg) begin
         sweep_calc = {1'b0, f} - delta;
      end else begin
         sweep_calc = {1'b0, f} + delta;
      end
   endfunction

   function automatic logic sweep_ovf(input logic [10:0] f,
                                      input logic        neg,
                                      input logic [2:0]  sh);
      return sweep_calc(f, neg, sh) > 12'd2047;
   endfunction

   // Period reload value; range 1..2048 so it needs 12 bits
   function automatic logic [11:0] period_of(input logic [10:0] f);
      return 12'd2048 - {1'b0, f};
   endfunction

   logic [3:0]  prescale_q,   prescale_d;
   logic [11:0] period_cnt_q, period_cnt_d;
   logic [3:0]  sweep_cnt_q,  sweep_cnt_d;
   logic [10:0] freq_cur_q,   freq_cur_d;
   logic [10:0] freq_out_q,   freq_out_d;
   logic        enabled_q,    enabled_d;
   logic        step_q,       step_d;

   logic [3:0]  sweep_reload_s;
   logic [11:0] sweep_new_s;
   logic        sweep_wr_s;

   // A sweep period of 0 still runs the sweep counter with a period of 8
   assign sweep_reload_s = (sweep_period == 3'd0) ? 4'd8 : {1'b0, sweep_period};
   assign sweep_new_s    = sweep_calc(freq_cur_q, sweep_negate, sweep_shift);

   // Next-state logic for the timer, sweep and frequency registers
   always_comb begin
      prescale_d   = prescale_q;
      period_cnt_d = period_cnt_q;
      sweep_cnt_d  = sweep_cnt_q;
      freq_cur_d   = freq_cur_q;
      freq_out_d   = freq_out_q;
      enabled_d    = enabled_q;
      step_d       = 1'b0;
      sweep_wr_s   = 1'b0;

      if (trigger) begin
         // Trigger wins over everything; a coincident sweep_tick is dropped
         freq_cur_d   = freq_in;
         freq_out_d   = freq_in;
         prescale_d   = 4'd0;
         period_cnt_d = period_of(freq_in);
         sweep_cnt_d  = sweep_reload_s;
         if ((sweep_shift != 3'd0) && !sweep_negate &&
             sweep_ovf(freq_in, 1'b0, sweep_shift)) begin
            enabled_d = 1'b0;
         end else begin
            enabled_d = 1'b1;
         end
      end else begin
         if (enabled_q) begin
            // Prescaler wrap clocks the period counter
            if (prescale_q == PRE_MAX) begin
               prescale_d = 4'd0;
               if (period_cnt_q == 12'd1) begin
                  step_d       = 1'b1;
                  period_cnt_d = period_of(freq_cur_q);
               end else begin
                  period_cnt_d = period_cnt_q - 12'd1;
               end
            end else begin
               prescale_d = prescale_q + 4'd1;
            end

            // Sweep computation happens only when the sweep counter expires
            if (sweep_tick) begin
               if (sweep_cnt_q <= 4'd1) begin
                  sweep_cnt_d = sweep_reload_s;
                  if (sweep_period != 3'd0) begin
                     if (sweep_new_s > 12'd2047) begin
                        enabled_d = 1'b0;
                     end else if (sweep_shift != 3'd0) begin
                        sweep_wr_s = 1'b1;
                        // Second check on the freshly written value
                        if (sweep_ovf(sweep_new_s[10:0], sweep_negate, sweep_shift)) begin
                           enabled_d = 1'b0;
                        end else begin
                           enabled_d = enabled_q;
                        end
                     end else begin
                        enabled_d = enabled_q;
                     end
                  end else begin
                     enabled_d = enabled_q;
                  end
               end else begin
                  sweep_cnt_d = sweep_cnt_q - 4'd1;
               end
            end else begin
               sweep_cnt_d = sweep_cnt_q;
            end
         end else begin
            prescale_d = prescale_q;
         end

         // Sweep write beats freq_we; freq_we still lands while disabled
         if (sweep_wr_s) begin
            freq_cur_d = sweep_new_s[10:0];
         end else if (freq_we) begin
            freq_cur_d = freq_in;
         end else begin
            freq_cur_d = freq_cur_q;
         end

         // freq_out freezes while the channel is disabled
         if (enabled_q) begin
            freq_out_d = freq_cur_d;
         end else begin
            freq_out_d = freq_out_q;
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q   <= 4'd0;
         period_cnt_q <= 12'd0;
         sweep_cnt_q  <= 4'd0;
         freq_cur_q   <= 11'd0;
         freq_out_q   <= 11'd0;
         enabled_q    <= 1'b0;
         step_q       <= 1'b0;
      end else begin
         prescale_q   <= prescale_d;
         period_cnt_q <= period_cnt_d;
         sweep_cnt_q  <= sweep_cnt_d;
         freq_cur_q   <= freq_cur_d;
         freq_out_q   <= freq_out_d;
         enabled_q    <= enabled_d;
         step_q       <= step_d;
      end
   end

   assign step     = step_q;
   assign freq_out = freq_out_q;
   assign enabled  = enabled_q;

endmodule

// File: tb/tb_square_freq_timer.sv
// -----------------------------------------------------------------------------
// tb_square_freq_timer
//
// Scoreboard bench for square_freq_timer (PRESCALE = 4). Stimulus pushes the
// expected cycle of every step pulse and every expected change of
// {enabled, freq_out}; a monitor pops and compares as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_square_freq_timer;

   logic        clk;
   logic        rst_n;
   logic        trigger;
   logic [10:0] freq_in;
   logic        freq_we;
   logic [2:0]  sweep_period;
   logic        sweep_negate;
   logic [2:0]  sweep_shift;
   logic        sweep_tick;
   logic        step;
   logic [10:0] freq_out;
   logic        enabled;

   int          tests;
   int          fails;
   int          cyc;
   int          step_seen;
   int          exp_c;
   logic [11:0] exp_s;
   logic [11:0] stat_prev;
   logic        end_req;
   logic        end_done;
   event        probe_ev;

   int          step_exp[$];
   logic [11:0] stat_exp[$];

   square_freq_timer #(.PRESCALE(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trigger      (trigger),
      .freq_in      (freq_in),
      .freq_we      (freq_we),
      .sweep_period (sweep_period),
      .sweep_negate (sweep_negate),
      .sweep_shift  (sweep_shift),
      .sweep_tick   (sweep_tick),
      .step         (step),
      .freq_out     (freq_out),
      .enabled      (enabled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter: number of rising edges seen so far
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares step pulses and status changes against the queues
   initial begin
      tests     = 0;
      fails     = 0;
      step_seen = 0;
      stat_prev = 12'hFFF;
      end_done  = 1'b0;
      forever begin
         @(negedge clk or probe_ev);
         if (step === 1'b1) begin
            step_seen = step_seen + 1;
            tests = tests + 1;
            if (step_exp.size() == 0) begin
               fails = fails + 1;
               $display("FAIL step_unexpected: step high at cycle %0d, required no step", cyc);
            end else begin
               exp_c = step_exp.pop_front();
               if (exp_c != cyc) begin
                  fails = fails + 1;
                  $display("FAIL step_time: step at cycle %0d, required cycle %0d", cyc, exp_c);
               end
            end
         end
         if ({enabled, freq_out} !== stat_prev) begin
            tests = tests + 1;
            if (stat_exp.size() == 0) begin
               fails = fails + 1;
               $display("FAIL status_unexpected: enabled=%0b freq_out=%0d at cycle %0d, required no change",
                        enabled, freq_out, cyc);
            end else begin
               exp_s = stat_exp.pop_front();
               if ({enabled, freq_out} !== exp_s) begin
                  fails = fails + 1;
                  $display("FAIL status: enabled=%0b freq_out=%0d at cycle %0d, required enabled=%0b freq_out=%0d",
                           enabled, freq_out, cyc, exp_s[11], exp_s[10:0]);
               end
            end
            stat_prev = {enabled, freq_out};
         end
         if (end_req && !end_done) begin
            end_done = 1'b1;
            tests = tests + 1;
            if (step_exp.size() != 0) begin
               fails = fails + 1;
               $display("FAIL steps_missing: %0d expected steps never seen, required 0", step_exp.size());
            end
            tests = tests + 1;
            if (stat_exp.size() != 0) begin
               fails = fails + 1;
               $display("FAIL status_missing: %0d expected status changes never seen, required 0", stat_exp.size());
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick_pulse();
      sweep_tick = 1'b1;
      @(negedge clk);
      sweep_tick = 1'b0;
   endtask

   // Issue a trigger (optionally with a coincident sweep_tick); t0 is the
   // cycle number of the trigger edge
   task automatic trig(input logic [10:0] f, input logic [2:0] per, input logic neg,
                       input logic [2:0] sh, input logic tk, output int t0);
      freq_in      = f;
      sweep_period = per;
      sweep_negate = neg;
      sweep_shift  = sh;
      sweep_tick   = tk;
      trigger      = 1'b1;
      @(negedge clk);
      trigger    = 1'b0;
      sweep_tick = 1'b0;
      t0 = cyc;
   endtask

   // Stimulus
   initial begin
      int t0;
      rst_n        = 1'b0;
      trigger      = 1'b0;
      freq_in      = 11'd0;
      freq_we      = 1'b0;
      sweep_period = 3'd0;
      sweep_negate = 1'b0;
      sweep_shift  = 3'd0;
      sweep_tick   = 1'b0;
      end_req      = 1'b0;

      // Reset state
      stat_exp.push_back({1'b0, 11'd0});
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2);

      // Period: f=2047 -> step every 4; freq_we 2040 -> every 32 after the current period
      stat_exp.push_back({1'b1, 11'd2047});
      stat_exp.push_back({1'b1, 11'd2040});
      trig(11'd2047, 3'd0, 1'b0, 3'd0, 1'b0, t0);
      step_exp.push_back(t0 + 4);
      step_exp.push_back(t0 + 8);
      step_exp.push_back(t0 + 12);
      step_exp.push_back(t0 + 44);
      step_exp.push_back(t0 + 76);
      wait_cyc(9);
      freq_in = 11'd2040;
      freq_we = 1'b1;
      @(negedge clk);
      freq_we = 1'b0;
      wait_cyc(66);

      // Asynchronous reset while step is high; probed before any clock edge
      stat_exp.push_back({1'b0, 11'd0});
      #2 rst_n = 1'b0;
      #1 -> probe_ev;
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(60);

      // Sweep up with overflow on the second check
      stat_exp.push_back({1'b1, 11'd1024});
      stat_exp.push_back({1'b0, 11'd1536});
      trig(11'd1024, 3'd1, 1'b0, 3'd1, 1'b0, t0);
      wait_cyc(3);
      tick_pulse();
      wait_cyc(5);

      // Sweep down: 1000 -> 750 (tick 2) -> 563 (tick 4)
      stat_exp.push_back({1'b1, 11'd1000});
      stat_exp.push_back({1'b1, 11'd750});
      stat_exp.push_back({1'b1, 11'd563});
      trig(11'd1000, 3'd2, 1'b1, 3'd2, 1'b0, t0);
      repeat (4) begin
         wait_cyc(2);
         tick_pulse();
      end
      wait_cyc(4);

      // Trigger-time overflow: 1500 + 750 > 2047, no step over a full period
      stat_exp.push_back({1'b0, 11'd1500});
      trig(11'd1500, 3'd0, 1'b0, 3'd1, 1'b0, t0);
      wait_cyc(2300);

      // Sweep off: 20 ticks leave the frequency alone
      stat_exp.push_back({1'b1, 11'd200});
      trig(11'd200, 3'd0, 1'b0, 3'd3, 1'b0, t0);
      repeat (20) begin
         wait_cyc(1);
         tick_pulse();
      end
      wait_cyc(3);

      // Tick coincident with trigger is ignored; a later tick sweeps 300 -> 450
      stat_exp.push_back({1'b1, 11'd300});
      stat_exp.push_back({1'b1, 11'd450});
      trig(11'd300, 3'd1, 1'b0, 3'd1, 1'b1, t0);
      wait_cyc(4);
      tick_pulse();
      wait_cyc(3);

      // f=2046 -> step every 8 cycles
      stat_exp.push_back({1'b1, 11'd2046});
      trig(11'd2046, 3'd0, 1'b0, 3'd0, 1'b0, t0);
      step_exp.push_back(t0 + 8);
      step_exp.push_back(t0 + 16);
      step_exp.push_back(t0 + 24);
      wait_cyc(28);

      #1 end_req = 1'b1;
      -> probe_ev;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
